ball_motion: RTL and testbench

Per-frame ball physics stage that directly feeds the ball renderer. It holds position, direction and alive state for CNT balls and advances every live ball once per frame tick. It bounces balls off the playfield walls and the paddle, spawns new balls on request, and retires balls that fall past the bottom. Outputs are packed position/alive vectors in the format the renderer consumes.

---
 rtl/ball_motion.sv | 146 ++++++++++++++
 tb/tb_ball_motion.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ball_motion.sv
// ball_motion: per-frame ball physics for CNT slots (walls, paddle, spawn, retire); define BALL_SPEEDUP_EN for paddle-bounce speedup
module ball_motion #(
  parameter int CNT = 3,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int RADIUS = 5,
  parameter int STEP = 2,
  parameter int PADDLE_Y = 440,
  parameter int PADDLE_HALF = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              launch,
  input  logic [9:0]        paddle_x,
  output logic [CNT*10-1:0] xs,
  output logic [CNT*10-1:0] ys,
  output logic [CNT-1:0]    balls,
  output logic              lost,
  output logic              busy
);
  localparam int IW = CNT > 1 ? $clog2(CNT) : 1;
  localparam logic signed [10:0] LO = 11'(RADIUS);
  localparam logic signed [10:0] X_MAX = 11'(SCREEN_W - 1 - RADIUS);
  localparam logic signed [10:0] Y_MAX = 11'(SCREEN_H - 1 - RADIUS);
  localparam logic signed [10:0] PAD_T = 11'(PADDLE_Y - RADIUS);
  localparam logic signed [11:0] HALF = 12'(PADDLE_HALF);
  localparam logic signed [11:0] NHALF = 12'(-PADDLE_HALF);
  localparam logic [9:0] XL = 10'(RADIUS);
  localparam logic [9:0] XR = 10'(SCREEN_W - 1 - RADIUS);
  localparam logic [9:0] SPAWN_Y = 10'(PADDLE_Y - RADIUS - 1);
  typedef enum logic [1:0] {IDLE, UPDATE, COMMIT} state_t;
  state_t state_q;
  logic [IW-1:0] idx_q, slot;
  logic [9:0] x_q [CNT];
  logic [9:0] y_q [CNT];
  logic [CNT-1:0] alive_q, dx_q, dy_q;
  logic pend_q, lost_acc_q;
  logic [2:0] step;
  logic signed [10:0] cx, cy, nx, ny, sstep;
  logic signed [11:0] dpx;
  logic x_lo, x_hi, y_top, pad_hit, y_bot, serve;
  logic [9:0] ux, uy, spawn_x;
  always_comb begin
    sstep = {8'b0, step};
    cx = {1'b0, x_q[idx_q]};
    cy = {1'b0, y_q[idx_q]};
    nx = dx_q[idx_q] ? cx + sstep : cx - sstep;
    ny = dy_q[idx_q] ? cy + sstep : cy - sstep;
    dpx = {nx[10], nx} - {2'b0, paddle_x};
    x_lo = nx < LO;
    x_hi = nx > X_MAX;
    y_top = ny < LO;
    pad_hit = dy_q[idx_q] && cy < PAD_T && ny >= PAD_T && dpx <= HALF && dpx >= NHALF;
    y_bot = ny > Y_MAX;
    ux = x_lo ? XL : x_hi ? XR : nx[9:0];
    uy = y_top ? XL : pad_hit ? SPAWN_Y : ny[9:0];
    spawn_x = paddle_x < XL ? XL : paddle_x > XR ? XR : paddle_x;
    serve = state_q == IDLE && !tick && pend_q;
    slot = '0;
    for (int i = CNT - 1; i >= 0; i--) slot = alive_q[i] ? slot : IW'(i);
  end
`ifdef BALL_SPEEDUP_EN
  logic [2:0] step_q, bcnt_q;
  assign step = step_q;
  always_ff @(posedge clk) begin
    if (rst || (state_q == COMMIT && alive_q == '0)) begin
      step_q <= 3'(STEP);
      bcnt_q <= '0;
    end else if (state_q == UPDATE && alive_q[idx_q] && pad_hit) begin
      bcnt_q <= bcnt_q + 3'd1;
      if (bcnt_q == 3'd7 && step_q < 3'(STEP + 2)) step_q <= step_q + 3'd1;
    end
  end
`else
  assign step = 3'(STEP);
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      alive_q <= '0;
      dx_q <= '1;
      dy_q <= '0;
      pend_q <= 1'b0;
      lost_acc_q <= 1'b0;
      xs <= '0;
      ys <= '0;
      balls <= '0;
      lost <= 1'b0;
      busy <= 1'b0;
      for (int i = 0; i < CNT; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      lost <= 1'b0;
      pend_q <= launch || (pend_q && !serve);
      case (state_q)
        IDLE: begin
          if (tick) begin
            state_q <= UPDATE;
            busy <= 1'b1;
            idx_q <= '0;
            lost_acc_q <= 1'b0;
          end else if (serve && !(&alive_q)) begin
            x_q[slot] <= spawn_x;
            y_q[slot] <= SPAWN_Y;
            dx_q[slot] <= 1'b1;
            dy_q[slot] <= 1'b0;
            alive_q[slot] <= 1'b1;
            xs[int'(slot)*10 +: 10] <= spawn_x;
            ys[int'(slot)*10 +: 10] <= SPAWN_Y;
            balls[slot] <= 1'b1;
          end
        end
        UPDATE: begin
          if (alive_q[idx_q]) begin
            x_q[idx_q] <= ux;
            if (x_lo) dx_q[idx_q] <= 1'b1;
            if (x_hi) dx_q[idx_q] <= 1'b0;
            if (y_top) dy_q[idx_q] <= 1'b1;
            if (pad_hit) dy_q[idx_q] <= 1'b0;
            // a retired ball keeps its last y
            if (!y_top && !pad_hit && y_bot) begin
              alive_q[idx_q] <= 1'b0;
              lost_acc_q <= 1'b1;
            end else y_q[idx_q] <= uy;
          end
          idx_q <= idx_q + 1'b1;
          if (idx_q == IW'(CNT - 1)) state_q <= COMMIT;
        end
        default: begin
          state_q <= IDLE;
          busy <= 1'b0;
          lost <= lost_acc_q;
          balls <= alive_q;
          for (int i = 0; i < CNT; i++) begin
            xs[i*10 +: 10] <= x_q[i];
            ys[i*10 +: 10] <= y_q[i];
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ball_motion.sv
// tb_ball_motion: randomized self-checking bench for ball_motion against a frame-level reference model
module tb_ball_motion;
  localparam int CNT = 3;
  localparam int STEP = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  logic launch = 1'b0;
  logic [9:0] paddle_x = 10'd320;
  logic [CNT*10-1:0] xs, ys;
  logic [CNT-1:0] balls;
  logic lost, busy;
  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  int mx[CNT], my[CNT], mdx[CNT], mdy[CNT], ma[CNT];
  int ox[CNT], oy[CNT], oa[CNT];
  int cd = 0, mpend = 0, flost = 0, olost = 0, mstep = STEP, mcnt = 0;

  ball_motion dut (
    .clk(clk), .rst(rst), .tick(tick), .launch(launch), .paddle_x(paddle_x),
    .xs(xs), .ys(ys), .balls(balls), .lost(lost), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < CNT; i++) begin
      mx[i] = 0; my[i] = 0; mdx[i] = 1; mdy[i] = 0; ma[i] = 0;
      ox[i] = 0; oy[i] = 0; oa[i] = 0;
    end
    cd = 0; mpend = 0; flost = 0; olost = 0; mstep = STEP; mcnt = 0;
  endfunction

  function automatic void m_spawn(int px);
    for (int i = 0; i < CNT; i++)
      if (ma[i] == 0) begin
        mx[i] = px < 5 ? 5 : px > 634 ? 634 : px;
        my[i] = 434; mdx[i] = 1; mdy[i] = 0; ma[i] = 1;
        ox[i] = mx[i]; oy[i] = my[i]; oa[i] = 1;
        return;
      end
  endfunction

  function automatic void m_frame(int px);
    flost = 0;
    for (int i = 0; i < CNT; i++) begin
      int nx, ny, d;
      if (ma[i] == 0) continue;
      nx = mx[i] + (mdx[i] != 0 ? mstep : -mstep);
      ny = my[i] + (mdy[i] != 0 ? mstep : -mstep);
      d = nx - px;
      if (d < 0) d = -d;
      if (nx < 5) begin mx[i] = 5; mdx[i] = 1; end
      else if (nx > 634) begin mx[i] = 634; mdx[i] = 0; end
      else mx[i] = nx;
      if (ny < 5) begin my[i] = 5; mdy[i] = 1; end
      else if (mdy[i] != 0 && my[i] < 435 && ny >= 435 && d <= 32) begin
        my[i] = 434; mdy[i] = 0;
`ifdef BALL_SPEEDUP_EN
        mcnt = (mcnt + 1) % 8;
        if (mcnt == 0 && mstep < STEP + 2) mstep++;
`endif
      end
      else if (ny > 474) begin ma[i] = 0; flost = 1; end
      else my[i] = ny;
    end
  endfunction

  function automatic void m_commit();
    int any;
    any = 0;
    for (int i = 0; i < CNT; i++) begin
      ox[i] = mx[i]; oy[i] = my[i]; oa[i] = ma[i]; any |= ma[i];
    end
    olost = flost;
    if (any == 0) begin mstep = STEP; mcnt = 0; end
  endfunction

  always @(posedge clk) begin
    olost = 0;
    if (rst) m_reset();
    else begin
      if (cd > 0) begin
        cd--;
        if (cd == 0) m_commit();
      end else if (tick) begin
        m_frame(int'(paddle_x));
        cd = CNT + 1;
      end else if (mpend != 0) begin
        m_spawn(int'(paddle_x));
        mpend = 0;
      end
      if (launch) mpend = 1;
    end
  end

  always @(negedge clk) begin
    int mask;
    if (chk_en) begin
      mask = 0;
      for (int i = 0; i < CNT; i++) mask |= oa[i] << i;
      chk("busy", int'(busy), int'(cd > 0));
      chk("lost", int'(lost), olost);
      chk("balls", int'(balls), mask);
      for (int i = 0; i < CNT; i++)
        if (oa[i] != 0) begin
          chk($sformatf("x[%0d]", i), int'(xs[i*10 +: 10]), ox[i]);
          chk($sformatf("y[%0d]", i), int'(ys[i*10 +: 10]), oy[i]);
        end
    end
  end

  function automatic logic [9:0] pick_paddle();
    int j, p;
    j = $urandom_range(0, CNT - 1);
    if (oa[j] != 0 && $urandom_range(0, 3) != 0) p = ox[j] + int'($urandom_range(0, 80)) - 40;
    else p = $urandom_range(0, 1023);
    if (p < 0) p = 0;
    if (p > 1023) p = 1023;
    return 10'(p);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic frame_run();
    tick = 1'b1; cyc(); tick = 1'b0;
    repeat (CNT + 1) cyc();
  endtask

  task automatic do_launch(input int px);
    paddle_x = 10'(px); launch = 1'b1; cyc(); launch = 1'b0; cyc();
  endtask

  initial begin
    int died;
    @(posedge clk);
    chk_en = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    do_launch(320);
    chk("spawn_x0", int'(xs[9:0]), 320);
    chk("spawn_y0", int'(ys[9:0]), 434);
    chk("spawn_balls", int'(balls), 1);
    tick = 1'b1; cyc(); tick = 1'b0;
    chk("busy_after_tick", int'(busy), 1);
    repeat (CNT) cyc();
    chk("x0_held_until_commit", int'(xs[9:0]), 320);
    cyc();
    chk("x0_frame1", int'(xs[9:0]), 322);
    chk("y0_frame1", int'(ys[9:0]), 432);
    chk("busy_done", int'(busy), 0);
    do_launch(1);
    chk("clamp_lo_x1", int'(xs[19:10]), 5);
    chk("balls_two", int'(balls), 3);
    do_launch(900);
    chk("clamp_hi_x2", int'(xs[29:20]), 634);
    chk("balls_three", int'(balls), 7);
    do_launch(320);
    chk("full_drop_balls", int'(balls), 7);
    chk("full_drop_x0", int'(xs[9:0]), 322);
    frame_run();
    chk("x0_frame2", int'(xs[9:0]), 324);
    chk("y0_frame2", int'(ys[9:0]), 430);
    chk("x1_frame2", int'(xs[19:10]), 7);
    chk("right_wall_x2", int'(xs[29:20]), 634);
    chk("y2_frame2", int'(ys[29:20]), 432);
    frame_run();
    chk("right_rebound_x2", int'(xs[29:20]), 632);
    chk("y2_frame3", int'(ys[29:20]), 430);
    tick = 1'b1; cyc(); tick = 1'b0;
    launch = 1'b1; cyc(); launch = 1'b0;
    rst = 1'b1; cyc(); cyc(); rst = 1'b0;
    chk("rst_xs", int'(xs), 0);
    chk("rst_ys", int'(ys), 0);
    chk("rst_balls", int'(balls), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_lost", int'(lost), 0);
    repeat (3) cyc();
    chk("rst_drops_pending", int'(balls), 0);
    do_launch(320);
    paddle_x = 10'd0;
    died = 0;
    for (int f = 1; f <= 600 && died == 0; f++) begin
      frame_run();
      if (f == 449) begin
        chk("pre_death_y0", int'(ys[9:0]), 473);
        chk("pre_death_x0", int'(xs[9:0]), 52);
      end
      if (balls[0] == 1'b0) begin
        died = f;
        chk("lost_pulse", int'(lost), 1);
        cyc();
        chk("lost_one_cycle", int'(lost), 0);
      end
    end
    chk("death_frame", died, 450);
    rst = 1'b1; cyc(); rst = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      tick = $urandom_range(0, 2) == 0;
      launch = $urandom_range(0, 11) == 0;
      rst = $urandom_range(0, 999) == 0;
      if (cd == 0) paddle_x = pick_paddle();
      cyc();
    end
    tick = 1'b0; launch = 1'b0; rst = 1'b0;
    repeat (CNT + 3) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
